// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the 32-bit to 16-bit asynchronous SRAM bridge.
// Holds the FSM state encoding, default parameters and the byte-to-word address helper.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] DEF_ADDR_BASE   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 2;

    // Offset wraps modulo 2^32; anything outside the 128K-word window aliases silently.
    function automatic logic [16:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return 17'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Moves one 32-bit MEM-stage word to/from a 16-bit asynchronous SRAM as two half-word
// accesses (low half first), holding ready low so the pipeline freezes meanwhile.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(WAIT_CYCLES - 2);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_wr_q;
    logic [16:0]      word_q;
    logic [15:0]      wdata_hi_q;
    logic [31:0]      rdata_q;
    logic [17:0]      sram_addr_q;
    logic             we_n_q;
    logic             oe_n_q;
    logic             dq_oe_q;
    logic [15:0]      dq_out_q;
    logic             phase_end;

    assign phase_end = (cnt_q == CNT_LAST);

    // Bus-side outputs are registered one cycle ahead: each branch sets what the next state drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_en || rd_en) begin
                        state_q     <= ST_LOW;
                        cnt_q       <= '0;
                        op_wr_q     <= wr_en;
                        word_q      <= word_index(address, ADDR_BASE);
                        wdata_hi_q  <= write_data[31:16];
                        sram_addr_q <= {word_index(address, ADDR_BASE), 1'b0};
                        we_n_q      <= !wr_en;
                        oe_n_q      <= wr_en;
                        dq_oe_q     <= wr_en;
                        dq_out_q    <= write_data[15:0];
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        state_q     <= ST_HIGH;
                        cnt_q       <= '0;
                        sram_addr_q <= {word_q, 1'b1};
                        we_n_q      <= !op_wr_q;
                        dq_out_q    <= wdata_hi_q;
                        if (!op_wr_q) rdata_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        // WE_N rises on the phase's last cycle so address/data are held past the edge.
                        we_n_q <= !op_wr_q || (cnt_q == CNT_PRELAST);
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (!op_wr_q) rdata_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        we_n_q <= !op_wr_q || (cnt_q == CNT_PRELAST);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !rd_en && !wr_en);
    assign read_data = rdata_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (WAIT_CYCLES 2 and 3), each on its own
// behavioural 256K x 16 SRAM with async read and write on the WE_N rising edge.
module tb_sram_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        rd2 = 1'b0, wr2 = 1'b0;
    logic [31:0] addr2 = '0, wd2 = '0;
    wire  [31:0] rdata2;
    wire         ready2, ub2, lb2, we2, ce2, oe2;
    wire  [15:0] dq2;
    wire  [17:0] sa2;

    logic        rd3 = 1'b0, wr3 = 1'b0;
    logic [31:0] addr3 = '0, wd3 = '0;
    wire  [31:0] rdata3;
    wire         ready3, ub3, lb3, we3, ce3, oe3;
    wire  [15:0] dq3;
    wire  [17:0] sa3;

    always #5 clk = ~clk;

    sram_controller #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd2), .wr_en(wr2), .address(addr2),
        .write_data(wd2), .read_data(rdata2), .ready(ready2), .SRAM_DQ(dq2),
        .SRAM_ADDR(sa2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_WE_N(we2),
        .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
    );

    sram_controller #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd3), .wr_en(wr3), .address(addr3),
        .write_data(wd3), .read_data(rdata3), .ready(ready3), .SRAM_DQ(dq3),
        .SRAM_ADDR(sa3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_WE_N(we3),
        .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
    );

    // Behavioural SRAMs; writes cut short by reset are not modelled.
    logic [15:0] mem2 [0:262143];
    logic [15:0] mem3 [0:262143];
    always @(posedge we2) if (rst_n) mem2[sa2] <= dq2;
    always @(posedge we3) if (rst_n) mem3[sa3] <= dq3;
    assign dq2 = (!oe2 && we2) ? mem2[sa2] : 16'hzzzz;
    assign dq3 = (!oe3 && we3) ? mem3[sa3] : 16'hzzzz;

    // A released bus floats to all-ones so a driving DUT is visible.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (dq2[gi]);
        pullup (dq3[gi]);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int oe_falls2 = 0;
    always @(negedge oe2) oe_falls2++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic access(input bit sel3, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, output int lat,
                          output logic [31:0] rdata, output logic [17:0] a_lo,
                          output logic [17:0] a_hi, output bit oe_low);
        int w;
        w = sel3 ? 3 : 2;
        lat = 0; rdata = '0; a_lo = '0; a_hi = '0; oe_low = 1'b0;
        @(negedge clk);
        if (sel3) begin wr3 = wr; rd3 = rd; addr3 = a; wd3 = d; end
        else      begin wr2 = wr; rd2 = rd; addr2 = a; wd2 = d; end
        #1;
        check("accept_cycle_ready", sel3 ? ready3 : ready2, 1'b0);
        for (int i = 1; i <= 4 * w; i++) begin
            @(negedge clk);
            if (i == 1)         a_lo = sel3 ? sa3 : sa2;
            if (i == 2 * w - 1) a_hi = sel3 ? sa3 : sa2;
            if (!(sel3 ? oe3 : oe2)) oe_low = 1'b1;
            if (sel3 ? ready3 : ready2) begin
                lat   = i;
                rdata = sel3 ? rdata3 : rdata2;
                break;
            end
        end
        if (!hold) begin
            if (sel3) begin wr3 = 1'b0; rd3 = 1'b0; end
            else      begin wr2 = 1'b0; rd2 = 1'b0; end
        end
        $display("dut%0d wr=%0b rd=%0b addr=%h data=%h lat=%0d read_data=%h lo=%h hi=%h",
                 w, wr, rd, a, d, lat, rdata, a_lo, a_hi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [17:0] lo, hi;
        bit          oel;

        // Reset state
        @(negedge clk);
        check("rst_ready", ready2, 1'b1);
        check("rst_read_data", rdata2, 32'h0);
        check("rst_sram_addr", sa2, 18'h0);
        check("rst_we_n", we2, 1'b1);
        check("rst_oe_n", oe2, 1'b1);
        check("rst_dq_released", dq2, 16'hFFFF);
        check("tied_enables", {ub2, lb2, ce2}, 3'b000);
        rst_n = 1'b1;

        // Write then read back
        access(0, 1, 0, 32'd1024, 32'hDEADBEEF, 0, lat, rd, lo, hi, oel);
        check("t1_wr_latency", lat, 5);
        check("t1_mem0", mem2[0], 16'hBEEF);
        check("t1_mem1", mem2[1], 16'hDEAD);
        access(0, 0, 1, 32'd1024, 32'h0, 0, lat, rd, lo, hi, oel);
        check("t1_rd_latency", lat, 5);
        check("t1_read_data", rd, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_read_hold", rdata2, 32'hDEADBEEF);
        check("t1_idle_ready", ready2, 1'b1);

        // Address mapping, including a below-base alias
        access(0, 1, 0, 32'd1032, 32'h12345678, 0, lat, rd, lo, hi, oel);
        check("t3_addr_low", lo, 18'd4);
        check("t3_addr_high", hi, 18'd5);
        check("t3_mem5", mem2[5], 16'h1234);
        access(0, 1, 0, 32'd1020, 32'h0BADF00D, 0, lat, rd, lo, hi, oel);
        check("alias_addr_low", lo, 18'h3FFFE);
        check("alias_addr_high", hi, 18'h3FFFF);
        check("alias_mem", mem2[18'h3FFFE], 16'hF00D);
        check("wr_keeps_read_data", rdata2, 32'hDEADBEEF);

        // Simultaneous rd_en/wr_en: write wins
        access(0, 1, 1, 32'd1028, 32'h0000FFFF, 0, lat, rd, lo, hi, oel);
        check("t4_oe_never_low", oel, 1'b0);
        check("t4_latency", lat, 5);
        check("t4_mem2", mem2[2], 16'hFFFF);
        check("t4_mem3", mem2[3], 16'h0000);
        check("t4_read_data_unchanged", rdata2, 32'hDEADBEEF);

        // Latency with WAIT_CYCLES=3
        access(1, 1, 0, 32'd1024, 32'hCAFEF00D, 0, lat, rd, lo, hi, oel);
        check("t2_w3_wr_latency", lat, 7);
        check("t2_w3_addr_high", hi, 18'd1);
        access(1, 0, 1, 32'd1024, 32'h0, 0, lat, rd, lo, hi, oel);
        check("t2_w3_rd_latency", lat, 7);
        check("t2_w3_read_data", rd, 32'hCAFEF00D);

        // Reset in the HIGH phase of a write
        @(negedge clk);
        wr2 = 1'b1; addr2 = 32'd1036; wd2 = 32'h12345A5A;
        repeat (3) @(negedge clk);
        check("t5_we_low_in_high", we2, 1'b0);
        check("t5_dq_driven", dq2, 16'h1234);
        rst_n = 1'b0; wr2 = 1'b0;
        #1;
        check("t5_we_n", we2, 1'b1);
        check("t5_oe_n", oe2, 1'b1);
        check("t5_dq_released", dq2, 16'hFFFF);
        check("t5_ready", ready2, 1'b1);
        check("t5_read_data_cleared", rdata2, 32'h0);
        check("t5_sram_addr", sa2, 18'h0);
        $display("dut2 reset asserted mid-write addr=%h", 32'd1036);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_low_half_written", mem2[6], 16'h5A5A);
        access(0, 0, 1, 32'd1024, 32'h0, 0, lat, rd, lo, hi, oel);
        check("t5_after_latency", lat, 5);
        check("t5_after_read_data", rd, 32'hDEADBEEF);

        // Back-to-back reads with rd_en held through DONE
        oe_falls2 = 0;
        access(0, 0, 1, 32'd1024, 32'h0, 1, lat, rd, lo, hi, oel);
        check("t6_first_data", rd, 32'hDEADBEEF);
        @(negedge clk);
        check("t6_gap_ready", ready2, 1'b0);
        check("t6_no_restart", oe2, 1'b1);
        addr2 = 32'd1032;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ready2) begin
                lat = i;
                rd  = rdata2;
                break;
            end
        end
        rd2 = 1'b0;
        $display("dut2 back-to-back rd addr=%h lat=%0d read_data=%h", 32'd1032, lat, rd);
        check("t6_second_latency", lat, 5);
        check("t6_second_data", rd, 32'h12345678);
        repeat (3) @(negedge clk);
        check("t6_access_count", oe_falls2, 2);
        check("t6_final_ready", ready2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
